// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM to word-addressed data memory controller.
// Byte/half/word loads and stores, big-endian lanes, sub-word stores done as
// read-modify-write. Optional misalignment trap: define MEM_ALIGN_CHECK_EN.
module mem_access_stage #(
  parameter int MEM_WORDS = 128
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_alu_result,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        align_err
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR} state_e;
  state_e state_q, state_d;

  // latched request; only the byte offset and word index of the address matter
  logic [AW+1:0] addr_q;
  logic [31:0]   sdata_q, alu_q;
  logic          rd_q, wr_q, uns_q, rw_q;
  logic [1:0]    size_q;
  logic [4:0]    rdst_q;

  logic [31:0] merged_q, merged_d;
  logic        wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign;

  logic unused_addr_bits;
  assign unused_addr_bits = ^ex_addr[31:AW+2];

  assign in_ready     = (state_q == IDLE);
  assign mem_address  = {{(32-AW){1'b0}}, addr_q[AW+1:2]};
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_rw_q;
  assign wb_data      = wb_data_q;

`ifdef MEM_ALIGN_CHECK_EN
  logic align_q;
  assign misalign = (rd_q | wr_q) &&
                    (((size_q == 2'b01) && addr_q[0]) ||
                     (size_q[1] && (addr_q[1:0] != 2'b00)));
  assign align_err = align_q;
  // error pulse coincides with the wb_valid of the trapped request
  always_ff @(posedge clock_in) begin
    if (reset) align_q <= 1'b0;
    else       align_q <= (state_q == ACCESS) && misalign;
  end
`else
  assign misalign  = 1'b0;
  assign align_err = 1'b0;
`endif

  // big-endian lane extraction and sign/zero extension for loads
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  always_comb begin
    ld_byte = 8'h00;
    case (addr_q[1:0])
      2'd0: ld_byte = mem_read_data[31:24];
      2'd1: ld_byte = mem_read_data[23:16];
      2'd2: ld_byte = mem_read_data[15:8];
      default: ld_byte = mem_read_data[7:0];
    endcase
    ld_half = addr_q[1] ? mem_read_data[15:0] : mem_read_data[31:16];
    if (size_q == 2'b00)      ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
    else if (size_q == 2'b01) ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
    else                      ld_ext = mem_read_data;
  end

  // old word with the addressed byte/half lane replaced by store data
  logic [31:0] merge_w;
  always_comb begin
    merge_w = mem_read_data;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0: merge_w[31:24] = sdata_q[7:0];
        2'd1: merge_w[23:16] = sdata_q[7:0];
        2'd2: merge_w[15:8]  = sdata_q[7:0];
        default: merge_w[7:0] = sdata_q[7:0];
      endcase
    end else begin
      if (addr_q[1]) merge_w[15:0]  = sdata_q[15:0];
      else           merge_w[31:16] = sdata_q[15:0];
    end
  end

  // state, request register, merge buffer and write-back registers
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      sdata_q    <= '0;
      alu_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      uns_q      <= 1'b0;
      rw_q       <= 1'b0;
      size_q     <= '0;
      rdst_q     <= '0;
      merged_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      merged_q   <= merged_d;
      wb_valid_q <= wb_valid_d;
      wb_rw_q    <= wb_rw_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      if (in_valid && in_ready) begin
        addr_q  <= ex_addr[AW+1:0];
        sdata_q <= ex_store_data;
        alu_q   <= ex_alu_result;
        rd_q    <= ex_mem_read;
        wr_q    <= ex_mem_write;
        uns_q   <= ex_unsigned;
        rw_q    <= ex_reg_write;
        size_q  <= ex_size;
        rdst_q  <= ex_rd;
      end
    end
  end

  // next state, memory strobes and write-back next values
  always_comb begin
    state_d        = state_q;
    merged_d       = merged_q;
    wb_valid_d     = 1'b0;
    wb_rw_d        = wb_rw_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_write_data = '0;
    case (state_q)
      IDLE: if (in_valid) state_d = ACCESS;
      ACCESS: begin
        if (misalign || !(rd_q || wr_q)) begin
          // pass-through, also the landing spot for trapped misaligned accesses
          wb_valid_d = 1'b1;
          wb_data_d  = alu_q;
          wb_rd_d    = rdst_q;
          wb_rw_d    = rw_q & ~misalign;
          state_d    = IDLE;
        end else if (rd_q) begin
          mem_read   = 1'b1;
          wb_valid_d = 1'b1;
          wb_data_d  = ld_ext;
          wb_rd_d    = rdst_q;
          wb_rw_d    = rw_q;
          state_d    = IDLE;
        end else if (size_q[1]) begin
          mem_write      = 1'b1;
          mem_write_data = sdata_q;
          wb_valid_d     = 1'b1;
          wb_data_d      = alu_q;
          wb_rd_d        = rdst_q;
          wb_rw_d        = 1'b0;
          state_d        = IDLE;
        end else begin
          mem_read = 1'b1;
          merged_d = merge_w;
          state_d  = RMW_WR;
        end
      end
      RMW_WR: begin
        mem_write      = 1'b1;
        mem_write_data = merged_q;
        wb_valid_d     = 1'b1;
        wb_data_d      = alu_q;
        wb_rd_d        = rdst_q;
        wb_rw_d        = 1'b0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // no memory traffic while reset is asserted
    if (reset) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end
endmodule
